// File: rtl/counter_pkg.sv
// Shared types and constants for the counter sequencer block.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/counter_core.sv
// Count register with load, enable and modulo wrap. The down path exists only
// when COUNT_DOWN_EN is defined; otherwise the core counts up only.
module counter_core
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             down,
    input  logic [WIDTH:0]   limit,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] up_next;
    logic [WIDTH-1:0] next_count;

    // Compare in WIDTH+1 bits so a limit of 2^WIDTH wraps correctly.
    assign up_next = (({1'b0, count} + (WIDTH+1)'(1)) == limit) ? '0 : count + WIDTH'(1);

`ifdef COUNT_DOWN_EN
    always_comb begin
        next_count = up_next;
        if (down) begin
            next_count = (count == '0) ? WIDTH'(limit - (WIDTH+1)'(1)) : count - WIDTH'(1);
        end
    end
`else
    logic unused_down;
    assign unused_down = down;
    assign next_count  = up_next;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Run-control FSM around counter_core: start/stop/pause, one-shot or wrapping
// passes, terminal-count flag. Down counting is enabled by COUNT_DOWN_EN.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] mod_val,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output state_t           fsm_state
);

    // Handshake: start is acted on only from IDLE or DONE; stop wins over
    // everything; pause is a level that freezes the count while running.
    state_t         state;
    logic [WIDTH:0] lim_q;
    logic           oneshot_q;
    logic           dir_q;
    logic [WIDTH:0] start_lim;
    logic           dir_eff;
    logic [WIDTH-1:0] load_val;
    logic           at_last;
    logic           active;
    logic           load;
    logic           en;

    assign start_lim = (mod_val == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, mod_val};

`ifdef COUNT_DOWN_EN
    assign dir_eff  = dir;
    assign load_val = dir ? WIDTH'(start_lim - (WIDTH+1)'(1)) : '0;
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign dir_eff    = 1'b0;
    assign load_val   = '0;
`endif

    assign active  = (state == RUN) || (state == PAUSE);
    assign at_last = dir_q ? (count == '0)
                           : (({1'b0, count} + (WIDTH+1)'(1)) == lim_q);
    assign tc      = active && at_last;
    assign load    = ((state == IDLE) || (state == DONE)) && start && !stop;
    assign en      = active && !stop && !pause && !(at_last && oneshot_q);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lim_q     <= '0;
            oneshot_q <= 1'b0;
            dir_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        lim_q     <= start_lim;
                        oneshot_q <= oneshot;
                        dir_q     <= dir_eff;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                RUN, PAUSE: begin
                    // Leaving PAUSE behaves like a RUN cycle, so counting resumes on that edge.
                    if (pause) begin
                        state <= PAUSE;
                    end else if (at_last && oneshot_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .down     (dir_q),
        .limit    (lim_q),
        .count    (count)
    );

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: vector table plus hand-written
// sequences for async reset and full-range (mod_val=0) passes.
module tb_counter_sequencer;
    import counter_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         pause = 1'b0;
    logic         oneshot = 1'b0;
    logic [W-1:0] mod_val = '0;
    logic         dir = 1'b0;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;
    state_t       fsm_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         start;
        logic         stop;
        logic         pause;
        logic         oneshot;
        logic [W-1:0] mod_val;
        logic [W-1:0] e_count;
        logic         e_tc;
        logic         e_busy;
        logic         e_done;
    } vec_t;

    vec_t vecs[$];

    counter_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .oneshot   (oneshot),
        .mod_val   (mod_val),
        .dir       (dir),
        .count     (count),
        .tc        (tc),
        .busy      (busy),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic st, input logic p, input logic o,
                                input logic [W-1:0] m, input logic [W-1:0] c,
                                input logic t, input logic b, input logic d);
        vec_t v;
        v.start = s; v.stop = st; v.pause = p; v.oneshot = o; v.mod_val = m;
        v.e_count = c; v.e_tc = t; v.e_busy = b; v.e_done = d;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic st, input logic p, input logic o,
                         input logic [W-1:0] m, input logic d);
        start = s; stop = st; pause = p; oneshot = o; mod_val = m; dir = d;
    endtask

    task automatic check_outs(input string tag, input logic [W-1:0] c, input logic t,
                              input logic b, input logic d);
        check_val({tag, " count"}, count, c);
        check_bit({tag, " tc"}, tc, t);
        check_bit({tag, " busy"}, busy, b);
        check_bit({tag, " done"}, done, d);
    endtask

    task automatic step_check(input string tag, input logic [W-1:0] c, input logic t,
                              input logic b, input logic d);
        @(posedge clk);
        #1;
        check_outs(tag, c, t, b, d);
    endtask

    initial begin
        logic [W-1:0] last_val;
        logic [W-1:0] e;

        //                 start stop pause os  mod   count tc busy done
        vecs.push_back(mk(1, 0, 0, 0, 4'd5, 4'd0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd3, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd4, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 4'd3, 4'd2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd3, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd4, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 4'd2, 4'd4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd4, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 4'd3, 4'd0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd2, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd2, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd2, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 4'd6, 4'd0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4'd0, 4'd2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4'd0, 4'd2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4'd0, 4'd2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd3, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd4, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd5, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'd0, 4'd0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd1, 4'd0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 4'd2, 4'd0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 4'd1, 0, 0, 0));

        // reset
        drive(0, 0, 0, 0, '0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", '0, 0, 0, 0);
        check_bit("reset state idle", fsm_state == IDLE, 1'b1);
        #3 reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].oneshot, vecs[i].mod_val, 0);
            step_check($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_tc,
                       vecs[i].e_busy, vecs[i].e_done);
        end
        drive(0, 0, 0, 0, '0, 0);

        // asynchronous reset in the middle of a cycle aborts the run at once
        drive(1, 0, 0, 0, 4'd5, 0);
        step_check("ar start", 4'd0, 0, 1, 0);
        drive(0, 0, 0, 0, '0, 0);
        step_check("ar c1", 4'd1, 0, 1, 0);
        step_check("ar c2", 4'd2, 0, 1, 0);
        step_check("ar c3", 4'd3, 0, 1, 0);
        #3 reset = 1'b0;
        #1;
        check_outs("ar async", '0, 0, 0, 0);
        check_bit("ar state idle", fsm_state == IDLE, 1'b1);
        #2 reset = 1'b1;

        // first start after release: one-shot pass over mod 4
        drive(1, 0, 0, 1, 4'd4, 0);
        step_check("post-rst start", 4'd0, 0, 1, 0);
        drive(0, 0, 0, 0, '0, 0);
        step_check("post-rst c1", 4'd1, 0, 1, 0);
        step_check("post-rst c2", 4'd2, 0, 1, 0);
        step_check("post-rst c3", 4'd3, 1, 1, 0);
        step_check("post-rst done", 4'd3, 0, 0, 1);
        check_bit("post-rst state done", fsm_state == DONE, 1'b1);

        // full-range pass with mod_val=0 and dir=1
`ifdef COUNT_DOWN_EN
        last_val = 4'd0;
        for (int k = 15; k >= 0; k--) exp_q.push_back(W'(k));
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd14);
`else
        last_val = 4'd15;
        for (int k = 0; k < 16; k++) exp_q.push_back(W'(k));
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
`endif
        drive(1, 0, 0, 0, 4'd0, 1);
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) drive(0, 0, 0, 0, '0, 1);
            e = exp_q.pop_front();
            check_val($sformatf("full c%0d", i), count, e);
            check_bit($sformatf("full tc%0d", i), tc, e == last_val);
            check_bit($sformatf("full busy%0d", i), busy, 1'b1);
        end
        drive(0, 1, 0, 0, '0, 0);
        step_check("full stop", 4'd14 + ((last_val == 4'd15) ? 4'd3 : 4'd0), 0, 0, 0);
        drive(0, 0, 0, 0, '0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, independent of clk.
REQ-004 start  input  1  begin a count run; sampled each clk edge.
REQ-005 stop  input  1  abort run, return to IDLE.
REQ-006 pause  input  1  level; hold count while high during a run.
REQ-007 oneshot  input  1  sampled with start; 1 = single pass then DONE, 0 = wrap continuously.
REQ-008 mod_val  input  WIDTH  modulus sampled with start; 0 means 2^WIDTH.
REQ-009 dir  input  1  sampled with start; 0 = up, 1 = down (only with COUNT_DOWN_EN).
REQ-010 count  output  WIDTH  registered count value.
REQ-011 tc  output  1  terminal-count flag, high exactly in cycles where count is the last value of the pass.
REQ-012 busy  output  1  high in RUN and PAUSE.
REQ-013 done  output  1  high while in DONE.

Function
REQ-014 FSM states SHALL be IDLE, RUN, PAUSE, DONE.
REQ-015 IDLE/DONE + start=1, stop=0: latch mod_val, oneshot, dir; load count = 0 (up) or limit-1 (down); enter RUN next edge.
REQ-016 limit = mod_val, or 2^WIDTH when mod_val=0; arithmetic in WIDTH+1 bits, no overflow.
REQ-017 RUN, pause=0: count +1 (up) / -1 (down) each edge.
REQ-018 Last value of pass: limit-1 (up), 0 (down); tc=1 in that cycle, combinationally from registered count and state RUN/PAUSE.
REQ-019 RUN at last value, oneshot=0: wrap to 0 (up) or limit-1 (down) next edge, stay RUN.
REQ-020 RUN at last value, oneshot=1: enter DONE next edge; count holds the last value.
REQ-021 RUN + pause=1: enter PAUSE, count holds; PAUSE + pause=0: return RUN, counting resumes next edge.
REQ-022 stop=1 in any state: IDLE next edge; count held; busy, done low.
REQ-023 Priority: stop > start > pause; start while busy ignored.
REQ-024 limit=1: count stays at 0, tc=1 every RUN cycle.
REQ-025 DONE + start restarts per REQ-015; DONE otherwise held until stop or start.

Reset
REQ-026 reset=0: state IDLE, count=0, tc=0, busy=0, done=0, latched limit/oneshot/dir cleared to 0.
REQ-027 Reset mid-run SHALL abort without completing the pass; first start after release behaves per REQ-015.

Configuration
REQ-028 Macro COUNT_DOWN_EN defined: dir honoured per REQ-009/017/018.
REQ-029 COUNT_DOWN_EN undefined: dir ignored, latched dir tied 0, up-count only, no down-path logic.

Structure
REQ-030 Shared package counter_pkg SHALL hold the state enum type and the default width constant.
REQ-031 Sub-module counter_core SHALL hold the count register with load/enable/direction/wrap; counter_sequencer holds FSM, latches, outputs.

Verification
REQ-032 WIDTH=4, start, mod_val=5, oneshot=0, up -> count 0,1,2,3,4,0,1...; tc high at each 4.
REQ-033 mod_val=3, oneshot=1 -> count 0,1,2; tc at 2; DONE with count=2, done=1, busy=0.
REQ-034 Pause high 3 cycles at count=2 -> count stays 2, busy=1; resumes 3 on first edge after pause low.
REQ-035 start and stop together in RUN -> IDLE, busy=0; reset=0 asserted mid-cycle -> count=0 immediately.
REQ-036 COUNT_DOWN_EN, dir=1, mod_val=0 -> count 15,14..0; tc at 0; wraps to 15.
